lcd_text_writer: RTL and testbench

LCD_TEXT_WRITER -- requirements
Module: lcd_text_writer

---
 rtl/lcd_pkg.sv | 30 +++
 rtl/lcd_byte_tx.sv | 80 ++++++++
 rtl/lcd_text_writer.sv | 133 +++++++++++++
 tb/tb_lcd_text_writer.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared constants and types for the HD44780-style text writer.
package lcd_pkg;

  // Controller command bytes
  localparam logic [7:0] CMD_FN    = 8'h38;  // 8-bit bus, 2 lines, 5x8 font
  localparam logic [7:0] CMD_CLR   = 8'h01;  // clear display
  localparam logic [7:0] CMD_MODE  = 8'h06;  // increment, no shift
  localparam logic [7:0] CMD_ON    = 8'h0C;  // display on, cursor off
  localparam logic [7:0] CMD_ADDR1 = 8'h80;  // DDRAM address of line 1
  localparam logic [7:0] CMD_ADDR2 = 8'hC0;  // DDRAM address of line 2

  typedef enum logic [3:0] {
    PWRUP, FN, CLR, MODE, ON, IDLE, ADDR1, CHAR, ADDR2, FIN
  } lcd_state_e;

  typedef enum logic [1:0] {
    TX_IDLE, TX_SETUP, TX_HIGH, TX_WAIT
  } tx_phase_e;

  // Width able to hold the largest of the four cycle counts without wrapping
  function automatic int cnt_width(int a, int b, int c, int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/lcd_byte_tx.sv
// One LCD byte transfer: setup cycle, EN-high window, then an EN-low wait.
// A new go is accepted while idle or on the ack cycle, so transfers chain
// back-to-back with no dead cycle between them.
module lcd_byte_tx
  import lcd_pkg::*;
#(
  parameter int EN_HIGH_CYC  = 25,
  parameter int WAIT_CYC     = 2500,
  parameter int CLR_WAIT_CYC = 100000,
  parameter int CNT_W        = 17
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       go,
  input  logic [7:0] tx_byte,
  input  logic       rs,
  input  logic       long_wait,
  output logic       ack,
  output logic [7:0] Din,
  output logic       RS,
  output logic       EN
);

  tx_phase_e        phase;
  logic [CNT_W-1:0] cnt;
  logic             lw;
  logic [CNT_W-1:0] wait_last;
  logic             accept;

  assign wait_last = lw ? CNT_W'(CLR_WAIT_CYC - 1) : CNT_W'(WAIT_CYC - 1);
  assign ack       = (phase == TX_WAIT) && (cnt == wait_last);
  assign accept    = go && ((phase == TX_IDLE) || ack);

  // Phase sequencing; Din/RS are loaded on accept and held until the next accept
  always_ff @(posedge clk) begin
    if (rst) begin
      phase <= TX_IDLE;
      cnt   <= '0;
      lw    <= 1'b0;
      Din   <= 8'h00;
      RS    <= 1'b0;
      EN    <= 1'b0;
    end else begin
      case (phase)
        TX_IDLE: ;
        TX_SETUP: begin
          EN    <= 1'b1;
          phase <= TX_HIGH;
          cnt   <= '0;
        end
        TX_HIGH: begin
          if (cnt == CNT_W'(EN_HIGH_CYC - 1)) begin
            EN    <= 1'b0;
            phase <= TX_WAIT;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        TX_WAIT: begin
          if (ack) begin
            phase <= TX_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: phase <= TX_IDLE;
      endcase
      if (accept) begin
        Din   <= tx_byte;
        RS    <= rs;
        lw    <= long_wait;
        phase <= TX_SETUP;
        cnt   <= '0;
      end
    end
  end

endmodule

// File: rtl/lcd_text_writer.sv
// Two-line character LCD writer: power-up init, then refreshes the whole
// display from a write-anytime character buffer on each start request.
module lcd_text_writer
  import lcd_pkg::*;
#(
  parameter int COLS         = 16,
  parameter int EN_HIGH_CYC  = 25,
  parameter int WAIT_CYC     = 2500,
  parameter int CLR_WAIT_CYC = 100000,
  parameter int POWERUP_CYC  = 2000000,
  localparam int N_CHARS     = 2 * COLS,
  localparam int AW          = $clog2(N_CHARS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [7:0]    Din,
  output logic          RS,
  output logic          RW,
  output logic          EN
);

  localparam int CNT_W = cnt_width(EN_HIGH_CYC, WAIT_CYC, CLR_WAIT_CYC, POWERUP_CYC);

  lcd_state_e               state, nxt_state;
  logic [AW-1:0]            idx, nxt_idx;
  logic [CNT_W-1:0]         pw_cnt;
  logic [N_CHARS-1:0][7:0]  buffer;
  logic                     go, ack, tx_rs, tx_long;
  logic [7:0]               tx_byte;

  assign RW = 1'b0;

  // Next-state decision; go launches the byte of the state being entered
  always_comb begin
    nxt_state = state;
    nxt_idx   = idx;
    go        = 1'b0;
    case (state)
      PWRUP: if (pw_cnt == CNT_W'(POWERUP_CYC - 1)) begin nxt_state = FN; go = 1'b1; end
      FN:    if (ack) begin nxt_state = CLR;  go = 1'b1; end
      CLR:   if (ack) begin nxt_state = MODE; go = 1'b1; end
      MODE:  if (ack) begin nxt_state = ON;   go = 1'b1; end
      ON:    if (ack) nxt_state = IDLE;
      IDLE:  if (start) begin nxt_state = ADDR1; go = 1'b1; end
      ADDR1: if (ack) begin nxt_state = CHAR; nxt_idx = '0; go = 1'b1; end
      CHAR: begin
        if (ack) begin
          if (idx == AW'(COLS - 1)) begin
            nxt_state = ADDR2;
            go        = 1'b1;
          end else if (idx == AW'(N_CHARS - 1)) begin
            nxt_state = FIN;
          end else begin
            nxt_idx = idx + AW'(1);
            go      = 1'b1;
          end
        end
      end
      ADDR2: if (ack) begin nxt_state = CHAR; nxt_idx = AW'(COLS); go = 1'b1; end
      FIN:   nxt_state = IDLE;
      default: nxt_state = PWRUP;
    endcase
  end

  // Byte to launch; a character is read from the buffer before any same-cycle write lands
  always_comb begin
    tx_byte = 8'h00;
    tx_rs   = 1'b0;
    tx_long = 1'b0;
    case (nxt_state)
      FN:    tx_byte = CMD_FN;
      CLR:   begin tx_byte = CMD_CLR; tx_long = 1'b1; end
      MODE:  tx_byte = CMD_MODE;
      ON:    tx_byte = CMD_ON;
      ADDR1: tx_byte = CMD_ADDR1;
      ADDR2: tx_byte = CMD_ADDR2;
      CHAR:  begin tx_byte = buffer[nxt_idx]; tx_rs = 1'b1; end
      default: ;
    endcase
  end

  // Controller FSM with registered busy/done
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= PWRUP;
      idx    <= '0;
      pw_cnt <= '0;
      busy   <= 1'b1;
      done   <= 1'b0;
    end else begin
      state <= nxt_state;
      idx   <= nxt_idx;
      if (state == PWRUP && nxt_state == PWRUP) pw_cnt <= pw_cnt + CNT_W'(1);
      else                                      pw_cnt <= '0;
      busy  <= (nxt_state != IDLE);
      done  <= (nxt_state == FIN);
    end
  end

  // Character buffer; writes accepted in any state, out-of-range ignored
  always_ff @(posedge clk) begin
    if (rst) begin
      buffer <= {N_CHARS{8'h20}};
    end else if (wr_en && (int'(wr_addr) < N_CHARS)) begin
      buffer[wr_addr] <= wr_data;
    end
  end

  lcd_byte_tx #(
    .EN_HIGH_CYC (EN_HIGH_CYC),
    .WAIT_CYC    (WAIT_CYC),
    .CLR_WAIT_CYC(CLR_WAIT_CYC),
    .CNT_W       (CNT_W)
  ) u_tx (
    .clk      (clk),
    .rst      (rst),
    .go       (go),
    .tx_byte  (tx_byte),
    .rs       (tx_rs),
    .long_wait(tx_long),
    .ack      (ack),
    .Din      (Din),
    .RS       (RS),
    .EN       (EN)
  );

endmodule

// File: tb/tb_lcd_text_writer.sv
// Scoreboard bench for lcd_text_writer: expected LCD byte stream is queued
// from a buffer model; a monitor checks each EN pulse, its timing and done.
module tb_lcd_text_writer;

  localparam int COLS = 4, N = 8, ENH = 2, WT = 4, CWT = 8, PWR = 10;

  logic       clk = 1'b0, rst = 1'b1, wr_en = 1'b0, start = 1'b0;
  logic [2:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic       busy, done, RS, RW, EN;
  logic [7:0] Din;

  always #5 clk = ~clk;

  lcd_text_writer #(
    .COLS(COLS), .EN_HIGH_CYC(ENH), .WAIT_CYC(WT),
    .CLR_WAIT_CYC(CWT), .POWERUP_CYC(PWR)
  ) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .busy(busy), .done(done), .Din(Din), .RS(RS), .RW(RW), .EN(EN)
  );

  typedef struct { logic [7:0] b; logic rs; int gap; } item_t;
  item_t      exq[$];
  logic [7:0] mbuf[N];
  int checks = 0, fails = 0, done_cnt = 0, exp_done = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor ----------------
  logic       prev_en, prev_busy, prev_done, prev_rs, hold_rs;
  logic [7:0] prev_din, hold_din;
  int         low_run, high_run, cur_gap;
  bit         gap_chk;
  item_t      it;

  always @(negedge clk) begin
    if (rst) begin
      prev_en = 1'b0; prev_busy = 1'b1; prev_done = 1'b0;
      low_run = 0; high_run = 0; gap_chk = 1'b0; cur_gap = WT;
      prev_din = Din; prev_rs = RS;
    end else begin
      if (EN) begin
        if (!prev_en) begin
          if (gap_chk) chk("gap_low_cycles", low_run, cur_gap + 1);
          chk("setup_din", Din, prev_din);
          chk("setup_rs", RS, prev_rs);
          if (exq.size() == 0) begin
            checks++; fails++;
            $display("FAIL unexpected_byte: got %0h, expected no transfer", Din);
            cur_gap = WT;
          end else begin
            it = exq.pop_front();
            chk("byte", Din, it.b);
            chk("rs", RS, it.rs);
            cur_gap = it.gap;
          end
          gap_chk = 1'b1; high_run = 1; hold_din = Din; hold_rs = RS;
        end else begin
          high_run++;
          chk("hold_din", Din, hold_din);
          chk("hold_rs", RS, hold_rs);
        end
        low_run = 0;
      end else begin
        if (prev_en) chk("en_high_cycles", high_run, ENH);
        low_run++;
      end
      if (done) begin
        done_cnt++;
        if (gap_chk) chk("fin_gap", low_run, cur_gap + 1);
        gap_chk = 1'b0;
      end else if (prev_busy && !busy && !prev_done) begin
        if (gap_chk) chk("idle_gap", low_run, cur_gap + 1);
        gap_chk = 1'b0;
      end
      prev_en = EN; prev_busy = busy; prev_done = done; prev_din = Din; prev_rs = RS;
    end
  end

  // ---------------- reference model helpers ----------------
  task automatic push_init();
    exq.push_back('{8'h38, 1'b0, WT});
    exq.push_back('{8'h01, 1'b0, CWT});
    exq.push_back('{8'h06, 1'b0, WT});
    exq.push_back('{8'h0C, 1'b0, WT});
  endtask

  task automatic push_refresh();
    exq.push_back('{8'h80, 1'b0, WT});
    for (int i = 0; i < COLS; i++) exq.push_back('{mbuf[i], 1'b1, WT});
    exq.push_back('{8'hC0, 1'b0, WT});
    for (int i = COLS; i < N; i++) exq.push_back('{mbuf[i], 1'b1, WT});
  endtask

  task automatic check_reset_outputs();
    chk("rst_din", Din, 8'h00);
    chk("rst_rs", RS, 1'b0);
    chk("rst_rw", RW, 1'b0);
    chk("rst_en", EN, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_busy", busy, 1'b1);
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 400 && busy; i++) @(negedge clk);
    chk(name, busy, 1'b0);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 400 && !done; i++) @(negedge clk);
    chk("done_seen", done, 1'b1);
    @(negedge clk);
    chk("busy_after_done", busy, 1'b0);
  endtask

  task automatic wait_en_byte(input logic [7:0] b);
    for (int i = 0; i < 400 && !(EN && Din == b); i++) @(negedge clk);
    chk("saw_en_byte", {EN, Din}, {1'b1, b});
  endtask

  task automatic write(input int a, input logic [7:0] d);
    wr_en = 1'b1; wr_addr = 3'(a); wr_data = d;
    mbuf[a] = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic pulse_start(input bit counts);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (counts) exp_done++;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] msg[N];
    int nw, a;
    logic [7:0] d;
    msg = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h57, 8'h58, 8'h59, 8'h5A};
    for (int i = 0; i < N; i++) mbuf[i] = 8'h20;

    // Reset and init sequence
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_outputs();
    push_init();
    rst = 1'b0;
    wait_idle("init_idle");
    chk("init_all_sent", exq.size(), 0);

    // Full refresh of "ABCDWXYZ"
    for (int i = 0; i < N; i++) write(i, msg[i]);
    push_refresh();
    pulse_start(1'b1);
    chk("busy_after_start", busy, 1'b1);
    wait_done();

    // Start while busy is ignored
    push_refresh();
    pulse_start(1'b1);
    start = 1'b1;
    repeat (20) @(negedge clk);
    start = 1'b0;
    wait_done();
    repeat (10) @(negedge clk);
    chk("single_refresh_done", done_cnt, exp_done);

    // Write after sample vs before sample
    mbuf[7] = 8'h52;
    push_refresh();
    pulse_start(1'b1);
    wait_en_byte(8'h41);
    write(0, 8'h51);
    write(7, 8'h52);
    wait_done();
    push_refresh();
    pulse_start(1'b1);
    wait_done();

    // Random writes, odd rounds write in the same cycle as start
    for (int r = 0; r < 6; r++) begin
      nw = $urandom_range(1, 5);
      for (int k = 0; k < nw; k++)
        write($urandom_range(0, N - 1), 8'($urandom_range(32, 126)));
      if (r % 2 == 1) begin
        a = $urandom_range(0, N - 1);
        d = 8'($urandom_range(32, 126));
        mbuf[a] = d;
        push_refresh();
        wr_en = 1'b1; wr_addr = 3'(a); wr_data = d; start = 1'b1;
        @(negedge clk);
        wr_en = 1'b0; start = 1'b0;
        exp_done++;
      end else begin
        push_refresh();
        pulse_start(1'b1);
      end
      wait_done();
    end

    // Reset in the middle of the 'C' transfer
    for (int i = 0; i < N; i++) write(i, msg[i]);
    push_refresh();
    pulse_start(1'b0);
    wait_en_byte(8'h43);
    rst = 1'b1;
    exq.delete();
    for (int i = 0; i < N; i++) mbuf[i] = 8'h20;
    @(negedge clk);
    check_reset_outputs();
    push_init();
    rst = 1'b0;
    wait_idle("reinit_idle");
    push_refresh();
    pulse_start(1'b1);
    wait_done();

    repeat (5) @(negedge clk);
    chk("done_count", done_cnt, exp_done);
    chk("queue_drained", exq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
